// File: rtl/led_palette_sequencer.sv
// Per-channel RGB palette generator: staggered triangle pulse, blink, solid and triggered fade.
// Optional gamma correction on pulse/fade outputs when LED_PALETTE_SEQUENCER_GAMMA_EN is defined.
module led_palette_sequencer #(
  parameter int parm_channel_count          = 4,
  parameter int parm_pulse_width            = 6,
  parameter int parm_FCLK                   = 40_000_000,
  parameter int parm_adjustments_per_second = 128
) (
  input  logic                              i_clk,
  input  logic                              i_arst_n,
  input  logic [3*parm_channel_count-1:0]   i_channel_mode,
  input  logic [3*parm_channel_count-1:0]   i_channel_rgb_en,
  input  logic [parm_channel_count-1:0]     i_trigger,
  input  logic                              i_freeze,
  output logic [8*parm_channel_count-1:0]   o_red_value,
  output logic [8*parm_channel_count-1:0]   o_green_value,
  output logic [8*parm_channel_count-1:0]   o_blue_value,
  output logic                              o_tick
);

  localparam int N  = parm_channel_count;
  localparam int W  = parm_pulse_width;
  localparam int D  = parm_FCLK / parm_adjustments_per_second;
  localparam int CW = $clog2(D);
  localparam logic [W-1:0]  MAX  = '1;
  localparam logic [W-1:0]  MIN  = W'(1);
  localparam logic [CW-1:0] LAST = CW'(D - 1);
  localparam logic [CW-1:0] CNT1 = CW'(1);

  // Spread the reset levels evenly from MIN to MAX so channels start phase-staggered.
  function automatic logic [W-1:0] init_level(input int k);
    if (N == 1) return MAX;
    return W'(1 + (k * ((2 ** W) - 2)) / ((N > 1) ? (N - 1) : 1));
  endfunction

  function automatic logic [7:0] expand(input logic [W-1:0] v);
    logic [7:0] r;
    r = '1;
    r[7 -: W] = v;
    return r;
  endfunction

  function automatic logic [7:0] correct(input logic [7:0] x);
`ifdef LED_PALETTE_SEQUENCER_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, x} * ({8'd0, x} + 16'd1);
    return p[15:8];
`else
    return x;
`endif
  endfunction

  logic [CW-1:0]    div_cnt;
  logic [W-1:0]     level [N];
  logic [W-1:0]     fade  [N];
  logic [N-1:0]     dir;
  logic             step_en;
  logic [8*N-1:0]   red_d, green_d, blue_d;
  logic [7:0]       val;

  assign o_tick  = (div_cnt == LAST);
  assign step_en = o_tick && !i_freeze;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= o_tick ? '0 : div_cnt + CNT1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      dir <= '0;
      for (int k = 0; k < N; k++) begin
        level[k] <= init_level(k);
        fade[k]  <= MIN;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        // A trigger wins over a same-cycle tick and is honoured while frozen.
        if (i_trigger[k]) begin
          fade[k] <= MAX;
        end else if (step_en && fade[k] != MIN) begin
          fade[k] <= fade[k] - MIN;
        end
        // Turning around at an extreme holds the level, giving a two-tick dwell.
        if (step_en) begin
          if (dir[k]) begin
            if (level[k] == MAX) dir[k] <= 1'b0;
            else                 level[k] <= level[k] + MIN;
          end else begin
            if (level[k] == MIN) dir[k] <= 1'b1;
            else                 level[k] <= level[k] - MIN;
          end
        end
      end
    end
  end

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    val     = '0;
    for (int k = 0; k < N; k++) begin
      case (i_channel_mode[3*k +: 3])
        3'd1:    val = 8'hFF;
        3'd2:    val = correct(expand(level[k]));
        3'd3:    val = dir[k] ? 8'hFF : 8'h00;
        3'd4:    val = (fade[k] == MIN) ? 8'h00 : correct(expand(fade[k]));
        default: val = 8'h00;
      endcase
      red_d[8*k +: 8]   = i_channel_rgb_en[3*k+2] ? val : 8'h00;
      green_d[8*k +: 8] = i_channel_rgb_en[3*k+1] ? val : 8'h00;
      blue_d[8*k +: 8]  = i_channel_rgb_en[3*k]   ? val : 8'h00;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_red_value   <= '0;
      o_green_value <= '0;
      o_blue_value  <= '0;
    end else begin
      o_red_value   <= red_d;
      o_green_value <= green_d;
      o_blue_value  <= blue_d;
    end
  end

endmodule

// File: tb/tb_led_palette_sequencer.sv
// Bench for led_palette_sequencer with N=4, W=6, D=4; a reference model feeds an expected-value queue.
module tb_led_palette_sequencer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [11:0] mode = '0;
  logic [11:0] rgb_en = '0;
  logic [3:0]  trigger = '0;
  logic        freeze = 1'b0;
  logic [31:0] red, green, blue;
  logic        tick;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic        t;
  } exp_t;
  exp_t sbq[$];

  int m_cnt;
  int m_level[N];
  int m_fade[N];
  bit m_dir[N];

  always #5 clk = ~clk;

  led_palette_sequencer #(
    .parm_channel_count(4),
    .parm_pulse_width(6),
    .parm_FCLK(512),
    .parm_adjustments_per_second(128)
  ) dut (
    .i_clk(clk),
    .i_arst_n(arst_n),
    .i_channel_mode(mode),
    .i_channel_rgb_en(rgb_en),
    .i_trigger(trigger),
    .i_freeze(freeze),
    .o_red_value(red),
    .o_green_value(green),
    .o_blue_value(blue),
    .o_tick(tick)
  );

  function automatic logic [7:0] gam(input int x);
`ifdef LED_PALETTE_SEQUENCER_GAMMA_EN
    return 8'((x * (x + 1)) / 256);
`else
    return 8'(x);
`endif
  endfunction

  function automatic int ex(input int v);
    return v * 4 + 3;
  endfunction

  function automatic logic [7:0] m_val(input int k);
    case (mode[3*k +: 3])
      3'd1:    return 8'd255;
      3'd2:    return gam(ex(m_level[k]));
      3'd3:    return m_dir[k] ? 8'd255 : 8'd0;
      3'd4:    return (m_fade[k] == 1) ? 8'd0 : gam(ex(m_fade[k]));
      default: return 8'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_level[0] = 1; m_level[1] = 21; m_level[2] = 42; m_level[3] = 63;
    for (int k = 0; k < N; k++) begin
      m_fade[k] = 1;
      m_dir[k]  = 1'b0;
    end
  endtask

  // One clock: push the model's prediction, advance the model, then compare after the edge.
  task automatic step();
    exp_t e;
    bit   mt;
    e.r = '0; e.g = '0; e.b = '0;
    for (int k = 0; k < N; k++) begin
      e.r[8*k +: 8] = rgb_en[3*k+2] ? m_val(k) : 8'd0;
      e.g[8*k +: 8] = rgb_en[3*k+1] ? m_val(k) : 8'd0;
      e.b[8*k +: 8] = rgb_en[3*k]   ? m_val(k) : 8'd0;
    end
    mt = (m_cnt == 3) && !freeze;
    m_cnt = (m_cnt + 1) % 4;
    for (int k = 0; k < N; k++) begin
      if (trigger[k]) m_fade[k] = 63;
      else if (mt && m_fade[k] > 1) m_fade[k] = m_fade[k] - 1;
      if (mt) begin
        if (m_dir[k]) begin
          if (m_level[k] == 63) m_dir[k] = 1'b0;
          else m_level[k] = m_level[k] + 1;
        end else begin
          if (m_level[k] == 1) m_dir[k] = 1'b1;
          else m_level[k] = m_level[k] - 1;
        end
      end
    end
    e.t = (m_cnt == 3);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    total++;
    if (red !== e.r) begin bad++; $display("FAIL sb_red: got %h want %h", red, e.r); end
    total++;
    if (green !== e.g) begin bad++; $display("FAIL sb_green: got %h want %h", green, e.g); end
    total++;
    if (blue !== e.b) begin bad++; $display("FAIL sb_blue: got %h want %h", blue, e.b); end
    total++;
    if (tick !== e.t) begin bad++; $display("FAIL sb_tick: got %b want %b", tick, e.t); end
  endtask

  task automatic test_reset();
    logic [31:0] want;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (red !== 32'd0) begin bad++; $display("FAIL reset_red: got %h want 0", red); end
    total++;
    if (green !== 32'd0) begin bad++; $display("FAIL reset_green: got %h want 0", green); end
    total++;
    if (blue !== 32'd0) begin bad++; $display("FAIL reset_blue: got %h want 0", blue); end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    model_reset();
    arst_n = 1'b1;
    mode   = {4{3'd2}};
    rgb_en = {4{3'b100}};
    step();
    want = {gam(255), gam(171), gam(87), gam(7)};
    total++;
    if (red !== want) begin bad++; $display("FAIL first_red: got %h want %h", red, want); end
    total++;
    if (green !== 32'd0 || blue !== 32'd0) begin
      bad++; $display("FAIL first_gb: got %h/%h want 0/0", green, blue);
    end
  endtask

  task automatic test_pulse();
    int ticks = 0;
    int mx = 0;
    int mn = 255;
    for (int i = 0; i < 300; i++) begin
      step();
      if (tick) ticks++;
      if (int'(red[7:0]) > mx) mx = int'(red[7:0]);
      if (int'(red[7:0]) < mn) mn = int'(red[7:0]);
    end
    total++;
    if (ticks != 75) begin bad++; $display("FAIL tick_count: got %0d want 75", ticks); end
    total++;
    if (mx != int'(gam(255))) begin bad++; $display("FAIL pulse_max: got %0d want %0d", mx, gam(255)); end
    total++;
    if (mn != int'(gam(7))) begin bad++; $display("FAIL pulse_min: got %0d want %0d", mn, gam(7)); end
  endtask

  task automatic test_fade();
    logic [7:0] seen[$];
    logic [7:0] last;
    mode[5:3]   = 3'd4;
    rgb_en[5:3] = 3'b111;
    step();
    last = red[15:8];
    trigger[1] = 1'b1;
    step();
    trigger[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (red[15:8] != last) seen.push_back(red[15:8]);
      last = red[15:8];
    end
    total++;
    if (seen.size() < 3) begin
      bad++; $display("FAIL fade_steps: got %0d values want >=3", seen.size());
    end else if (seen[0] !== gam(255) || seen[1] !== gam(251) || seen[2] !== gam(247)) begin
      bad++; $display("FAIL fade_seq: got %0d,%0d,%0d want %0d,%0d,%0d",
                      seen[0], seen[1], seen[2], gam(255), gam(251), gam(247));
    end
    total++;
    if (green[15:8] !== red[15:8] || blue[15:8] !== red[15:8]) begin
      bad++; $display("FAIL fade_white: got %h/%h/%h want equal", red[15:8], green[15:8], blue[15:8]);
    end
    trigger[1] = 1'b1;
    step();
    trigger[1] = 1'b0;
    step();
    total++;
    if (red[15:8] !== gam(255)) begin bad++; $display("FAIL retrigger: got %0d want %0d", red[15:8], gam(255)); end
    for (int i = 0; i < 62 * 4 + 4; i++) step();
    total++;
    if (red[15:8] !== 8'd0) begin bad++; $display("FAIL fade_end: got %0d want 0", red[15:8]); end
  endtask

  task automatic test_freeze();
    logic [31:0] cap_r, cap_g, cap_b;
    int ticks = 0;
    freeze = 1'b1;
    step();
    cap_r = red; cap_g = green; cap_b = blue;
    for (int i = 0; i < 80; i++) begin
      step();
      if (tick) ticks++;
    end
    total++;
    if (red !== cap_r || green !== cap_g || blue !== cap_b) begin
      bad++; $display("FAIL freeze_hold: got %h want %h", red, cap_r);
    end
    total++;
    if (ticks != 20) begin bad++; $display("FAIL freeze_ticks: got %0d want 20", ticks); end
    trigger[1] = 1'b1;
    step();
    trigger[1] = 1'b0;
    step();
    total++;
    if (red[15:8] !== gam(255)) begin bad++; $display("FAIL freeze_trig: got %0d want %0d", red[15:8], gam(255)); end
    freeze = 1'b0;
    for (int i = 0; i < 40; i++) step();
  endtask

  task automatic test_modes();
    mode[8:6] = 3'd3;
    for (int i = 0; i < 60; i++) step();
    mode[8:6] = 3'd1;
    step();
    total++;
    if (red[23:16] !== 8'd255) begin bad++; $display("FAIL solid: got %0d want 255", red[23:16]); end
    mode[8:6] = 3'd7;
    step();
    total++;
    if (red[23:16] !== 8'd0) begin bad++; $display("FAIL mode7: got %0d want 0", red[23:16]); end
    mode[8:6] = 3'd2;
    for (int i = 0; i < 20; i++) step();
    mode[2:0]   = 3'd1;
    rgb_en[2:0] = 3'b011;
    step();
    total++;
    if (red[7:0] !== 8'd0 || green[7:0] !== 8'd255 || blue[7:0] !== 8'd255) begin
      bad++; $display("FAIL mask: got %h/%h/%h want 00/ff/ff", red[7:0], green[7:0], blue[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    mode   = {4{3'd4}};
    rgb_en = {4{3'b111}};
    trigger = 4'hF;
    repeat (3) step();
    trigger = 4'h0;
    for (int i = 0; i < 30; i++) step();
  endtask

  task automatic test_async_reset();
    logic [31:0] want;
    mode   = {4{3'd1}};
    rgb_en = {4{3'b111}};
    step();
    #2;
    arst_n = 1'b0;
    #1;
    total++;
    if (red !== 32'd0 || green !== 32'd0 || blue !== 32'd0) begin
      bad++; $display("FAIL async_rst: got %h/%h/%h want 0", red, green, blue);
    end
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL async_tick: got %b want 0", tick); end
    model_reset();
    #1;
    arst_n = 1'b1;
    mode   = {4{3'd2}};
    rgb_en = {4{3'b100}};
    step();
    want = {gam(255), gam(171), gam(87), gam(7)};
    total++;
    if (red !== want) begin bad++; $display("FAIL restart_red: got %h want %h", red, want); end
    for (int i = 0; i < 12; i++) step();
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_fade();
    test_freeze();
    test_modes();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_palette_sequencer.md
Name: led_palette_sequencer

Overview:
Parametrised successor to the fixed 4-colour/4-basic LED pulser. It generates 8-bit RGB palette values for N channels. Each channel has its own runtime mode, colour mask, phase-staggered triangle pulse and triggered fade-out. It sits between the tester status logic and the LED PWM driver, and its outputs feed the PWM driver's palette inputs directly.

Parameters:
parm_channel_count, 4, number of RGB channels N (1..16)
parm_pulse_width, 6, pulse level width W in bits (2..8)
parm_FCLK, 40_000_000, i_clk frequency in Hz
parm_adjustments_per_second, 128, pulse tick rate; divisor D = parm_FCLK / parm_adjustments_per_second (must be >= 2)

Ports:
i_clk  in  1  system clock
i_arst_n  in  1  asynchronous active-low reset
i_channel_mode  in  3*N  per-channel mode, ch k at [3k+2:3k]: 0 off, 1 solid, 2 pulse, 3 blink, 4 fade; 5-7 behave as off
i_channel_rgb_en  in  3*N  per-channel colour mask, ch k at [3k+2:3k] = {R,G,B}
i_trigger  in  N  single-cycle fade (re)start strobe per channel
i_freeze  in  1  hold all pulse/fade state while high
o_red_value  out  8*N  red palette, ch k at [8k+7:8k]
o_green_value  out  8*N  green palette
o_blue_value  out  8*N  blue palette
o_tick  out  1  one-cycle strobe on each adjustment tick

Behaviour:
- Reset is asynchronous and active-low on i_arst_n. All state clears immediately when it asserts and releases on the next i_clk edge.
- Reset values: all outputs 0; o_tick 0; divider count 0; all directions 0 (down); fade levels at MIN.
- Reset pulse level for ch k is 1 + (k*(MAX-1))/(N-1), with MAX = 2^W-1. When N=1 the level is MAX. Example N=4, W=6: 1, 21, 42, 63.
- Tick divider: counts 0..D-1 and wraps to 0. o_tick is high in the cycle the count equals D-1. The counter runs regardless of i_freeze.
- Pulse update on o_tick when i_freeze=0, per channel. The pulse counter runs in every mode:
  - dir=1: if level == MAX, set dir=0 and hold the level; else level+1.
  - dir=0: if level == MIN (MIN=1), set dir=1 and hold the level; else level-1.
  - Result: each extreme dwells for two ticks. Full period = 2*(MAX-1)+2 ticks.
- Fade state per channel:
  - i_trigger[k] sets fade level to MAX on the next edge. This takes priority over a same-cycle tick and applies even while frozen.
  - On each unfrozen tick, a fade level above MIN decrements by 1 and stops at MIN.
  - A trigger during an active fade restarts it at MAX.
- Level expansion E(v), W bits to 8 bits: v left-justified with the low (8-W) bits filled with 1s. E(MAX)=255. For W=6, E(1)=7.
- Per-colour output, registered, one cycle after the inputs/state:
  - Masked-off colour: 0 in every mode.
  - off (and modes 5-7): 0.
  - solid: 255.
  - pulse: E(pulse level).
  - blink: 255 while dir=1, else 0.
  - fade: E(fade level), or 0 when fade level == MIN.
- Mode or mask changes take effect on the next edge. They never disturb the pulse counter or fade state, so channels stay phase-staggered.
- Counters must not wrap past MIN or MAX. Width arithmetic is W bits and unsigned.

Optional Feature:
- Macro LED_PALETTE_SEQUENCER_GAMMA_EN.
- When defined: every non-constant output (pulse, fade) becomes G(x) = (x*(x+1))>>8, where x is the 8-bit value before correction. G(255)=255, G(0)=0, G(7)=0, G(128)=64.
  - The correction is computed combinationally before the same output register, so latency is unchanged.
  - Solid, blink and off values are unaffected.
- When undefined: values are passed uncorrected and no multiplier logic is inferred.

Test Plan:
1. N=4, W=6, D=4; release reset, all channels mode 2, mask 3'b100 -> first outputs after one cycle: red bytes 7, 87, 171, 255 (ch0..3); green and blue 0.
2. Ch0 pulse, ticks observed -> level 1 holds for 2 ticks, then rises 2..63, holds at 63 for 2 ticks, then falls; o_tick period 4 cycles.
3. Ch1 mode 4, mask 3'b111, pulse i_trigger[1] -> all colours 255 next cycle, then decrement by 4 per tick (251, 247, ...) to 0 after 62 ticks; retrigger at tick 10 -> back to 255.
4. i_freeze=1 for 20 ticks, mode 2 -> outputs constant; o_tick still pulses; trigger still loads MAX; on release, stepping resumes from the held level.
5. Ch2 mode 3 then mode 1 mid-period, then mode 7 -> blink 255/0 tracking dir; then 255 next cycle; then 0. The pulse phase is unchanged when the channel returns to mode 2.
6. Drop i_arst_n asynchronously mid-tick -> all outputs 0 before the next i_clk edge; after release, levels restart at 1, 21, 42, 63. With GAMMA_EN defined, the test 1 values become 0, 29, 114, 255.
